// File: rtl/instr_match_unit.sv
// rtl/instr_match_unit.sv - runtime-programmable commit instruction matcher
// Per-entry saturating hit counters and a trace FIFO with a valid/ready drain port.
module instr_match_unit #(
   parameter int NrCommitPorts = 2,
   parameter int NrPatterns    = 8,
   parameter int FifoDepth     = 16,
   parameter int CntWidth      = 32,
   parameter int PcWidth       = 64
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [NrCommitPorts-1:0]               commit_valid_i,
   input  logic [NrCommitPorts-1:0][31:0]         commit_instr_i,
   input  logic [NrCommitPorts-1:0][PcWidth-1:0]  commit_pc_i,
   input  logic                                   cfg_we_i,
   input  logic [$clog2(NrPatterns)-1:0]          cfg_idx_i,
   input  logic                                   cfg_en_i,
   input  logic [31:0]                            cfg_mask_i,
   input  logic [31:0]                            cfg_value_i,
   input  logic                                   cnt_clear_i,
   input  logic [$clog2(NrPatterns)-1:0]          cnt_idx_i,
   output logic [CntWidth-1:0]                    cnt_o,
   output logic [CntWidth-1:0]                    drop_cnt_o,
   output logic                                   trace_valid_o,
   input  logic                                   trace_ready_i,
   output logic [PcWidth-1:0]                     trace_pc_o,
   output logic [31:0]                            trace_instr_o,
   output logic [$clog2(NrPatterns)-1:0]          trace_idx_o,
   output logic                                   fifo_full_o
);

   localparam int IdxW = $clog2(NrPatterns);
   localparam int AW   = $clog2(FifoDepth);
   localparam int IncW = $clog2(NrCommitPorts + 1);
   localparam logic [AW:0] DepthW = (AW+1)'(FifoDepth);

   logic [NrPatterns-1:0] r_en;
   logic [31:0]           r_mask  [NrPatterns];
   logic [31:0]           r_value [NrPatterns];
   logic [CntWidth-1:0]   r_cnt   [NrPatterns];
   logic [CntWidth-1:0]   r_drop;
   logic [AW:0]           r_wptr;
   logic [AW:0]           r_rptr;
   logic [PcWidth-1:0]    r_fifo_pc    [FifoDepth];
   logic [31:0]           r_fifo_instr [FifoDepth];
   logic [IdxW-1:0]       r_fifo_idx   [FifoDepth];

   logic [31:0]              w_norm  [NrCommitPorts];
   logic [NrCommitPorts-1:0] w_hit;
   logic [IdxW-1:0]          w_win   [NrCommitPorts];
   logic [IncW-1:0]          w_inc   [NrPatterns];
   logic [AW:0]              w_count;
   logic [AW:0]              w_free;
   logic [AW:0]              w_slot;
   logic [NrCommitPorts-1:0] w_push;
   logic [AW-1:0]            w_waddr [NrCommitPorts];
   logic [IncW-1:0]          w_ndrop;
   logic                     w_empty;
   logic                     w_pop;

   function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                   input logic [IncW-1:0] b);
      logic [CntWidth:0] s;
      s = {1'b0, a} + (CntWidth+1)'(b);
      return s[CntWidth] ? '1 : s[CntWidth-1:0];
   endfunction

   // Compressed encodings carry no upper halfword; descending scan leaves the lowest hit as winner.
   always_comb begin
      for (int p = 0; p < NrCommitPorts; p++) begin
         w_norm[p] = commit_instr_i[p];
         if (commit_instr_i[p][1:0] != 2'b11) w_norm[p][31:16] = '0;
         w_hit[p] = 1'b0;
         w_win[p] = '0;
         for (int k = NrPatterns - 1; k >= 0; k--) begin
            if (commit_valid_i[p] && r_en[k] &&
                ((w_norm[p] & r_mask[k]) == (r_value[k] & r_mask[k]))) begin
               w_hit[p] = 1'b1;
               w_win[p] = IdxW'(k);
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NrPatterns; k++) begin
         w_inc[k] = '0;
         for (int p = 0; p < NrCommitPorts; p++) begin
            if (w_hit[p] && (w_win[p] == IdxW'(k))) w_inc[k] = w_inc[k] + IncW'(1);
         end
      end
   end

   // Free space is taken from the start-of-cycle occupancy, so a same-cycle pop never helps.
   always_comb begin
      w_count = r_wptr - r_rptr;
      w_free  = DepthW - w_count;
      w_slot  = '0;
      w_ndrop = '0;
      for (int p = 0; p < NrCommitPorts; p++) begin
         w_push[p]  = 1'b0;
         w_waddr[p] = r_wptr[AW-1:0] + w_slot[AW-1:0];
         if (w_hit[p]) begin
            if (w_slot < w_free) begin
               w_push[p] = 1'b1;
               w_slot    = w_slot + (AW+1)'(1);
            end else begin
               w_ndrop = w_ndrop + IncW'(1);
            end
         end
      end
   end

   assign w_empty = (r_wptr == r_rptr);
   assign w_pop   = !w_empty && trace_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_en   <= '0;
         r_drop <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         for (int k = 0; k < NrPatterns; k++) begin
            r_mask[k]  <= '0;
            r_value[k] <= '0;
            r_cnt[k]   <= '0;
         end
      end else begin
         if (cfg_we_i) begin
            r_en[cfg_idx_i]    <= cfg_en_i;
            r_mask[cfg_idx_i]  <= cfg_mask_i;
            r_value[cfg_idx_i] <= cfg_value_i;
         end
         for (int k = 0; k < NrPatterns; k++) begin
            r_cnt[k] <= cnt_clear_i ? '0 : sat_add(r_cnt[k], w_inc[k]);
         end
         r_drop <= cnt_clear_i ? '0 : sat_add(r_drop, w_ndrop);
         r_wptr <= r_wptr + w_slot;
         r_rptr <= r_rptr + (AW+1)'(w_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      for (int p = 0; p < NrCommitPorts; p++) begin
         if (w_push[p]) begin
            r_fifo_pc[w_waddr[p]]    <= commit_pc_i[p];
            r_fifo_instr[w_waddr[p]] <= w_norm[p];
            r_fifo_idx[w_waddr[p]]   <= w_win[p];
         end
      end
   end

   assign cnt_o         = r_cnt[cnt_idx_i];
   assign drop_cnt_o    = r_drop;
   assign trace_valid_o = !w_empty;
   assign trace_pc_o    = r_fifo_pc[r_rptr[AW-1:0]];
   assign trace_instr_o = r_fifo_instr[r_rptr[AW-1:0]];
   assign trace_idx_o   = r_fifo_idx[r_rptr[AW-1:0]];
   assign fifo_full_o   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: doc/instr_match_unit.md
Name: instr_match_unit

Overview:
- Parametrised, runtime-programmable successor to the tracer's fixed opcode-pattern decoding.
- Holds NrPatterns mask/value entries that software programs at run time and matches every committed instruction against them.
- Keeps a saturating hit counter per entry and pushes matching instructions into a trace FIFO with a valid/ready drain port.
- Sits beside the commit stage, observing up to NrCommitPorts commits per cycle; it never stalls the core.

Parameters:
- NrCommitPorts, 2, commit ports observed per cycle (1..4)
- NrPatterns, 8, number of programmable mask/value entries (power of 2, 2..32)
- FifoDepth, 16, trace FIFO depth in records (power of 2, >= NrCommitPorts)
- CntWidth, 32, width of each hit counter and of the drop counter
- PcWidth, 64, PC width carried in trace records

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- commit_valid_i  in  NrCommitPorts  per-port commit strobe
- commit_instr_i  in  NrCommitPorts x 32  committed instruction word
- commit_pc_i  in  NrCommitPorts x PcWidth  committed PC
- cfg_we_i  in  1  pattern table write strobe
- cfg_idx_i  in  log2(NrPatterns)  entry index to write
- cfg_en_i  in  1  entry enable, written with the entry
- cfg_mask_i  in  32  care mask; 1 = bit compared
- cfg_value_i  in  32  compare value
- cnt_clear_i  in  1  synchronous clear of all hit counters and the drop counter
- cnt_idx_i  in  log2(NrPatterns)  counter read select
- cnt_o  out  CntWidth  hit counter selected by cnt_idx_i (combinational read of a register)
- drop_cnt_o  out  CntWidth  records dropped because the FIFO was full
- trace_valid_o  out  1  FIFO head is valid
- trace_ready_i  in  1  consumer accepts the head record
- trace_pc_o  out  PcWidth  head record PC
- trace_instr_o  out  32  head record instruction word
- trace_idx_o  out  log2(NrPatterns)  matching pattern index
- fifo_full_o  out  1  FIFO occupancy == FifoDepth

Behaviour:
- Reset: all entries set to en=0, mask=0, value=0; all counters 0; FIFO empty; trace_valid_o=0; fifo_full_o=0; drop_cnt_o=0. Reset may assert at any time; all state clears immediately with no handshake completion.
- Normalisation: when instr[1:0] != 2'b11 (compressed), instr[31:16] is forced to 0 before matching and in the stored record.
- Match: entry k hits port p iff en[k] and ((norm_instr & mask[k]) == (value[k] & mask[k])). An entry with mask=0 and en=1 matches every commit.
- Priority: the lowest-index hitting entry wins. Only the winner's counter increments and only the winner's index is recorded. At most one record is produced per port per cycle.
- Counters: for each entry, increment by the number of ports it won that cycle (0..NrCommitPorts). Counters saturate at all-ones and never wrap.
- cnt_clear_i: all counters and drop_cnt become 0 the next cycle. Clear wins over same-cycle increments; those hits are lost.
- Config write: takes effect the cycle after cfg_we_i. Commits in the write cycle use the old entry contents. Writes never disturb the counters.
- FIFO push: matching ports are pushed in ascending port order, up to the free slots available at the start of the cycle. A pop in the same cycle does NOT create space for that cycle's pushes. Records that do not fit are dropped, and drop_cnt increments by the number dropped (saturating).
- FIFO pop: the head is consumed when trace_valid_o && trace_ready_i. Outputs come from registered storage. A record pushed in cycle N is visible at the head in cycle N+1 at the earliest.
- Pointers: read/write pointers carry one extra wrap bit. full = MSBs differ and low bits equal; empty = pointers equal.
- trace_* outputs are don't-care when trace_valid_o=0. Pop with trace_valid_o=0 has no effect.

Test Plan:
- Reset defaults, then commit 0x00000013 on port 0 -> no entry enabled, no record, all counters 0, trace_valid_o=0.
- Entry 0 mask=0x0000707F, value=0x00000013 (ADDI); entry 1 mask=0x0000007F, value=0x00000013 (OP-IMM). Commit 0x00A00513 -> idx 0 recorded, cnt[0]=1, cnt[1]=0.
- Entry 2 mask=0x0000E003, value=0x00004002 (C.LWSP). Commit 0xFFFF4502 -> record instr=0x00004502, idx=2.
- FifoDepth=4, both ports matching every cycle, trace_ready_i=0 for 3 cycles -> 4 records stored, fifo_full_o=1, drop_cnt=2. Then hold ready=1 -> records drain in order port0,port1,port0,port1.
- CntWidth=4, preload 15 hits, one more -> cnt stays 15. cnt_clear_i asserted together with a hit -> cnt=0 next cycle.
- cfg write of entry 0 to en=0 in the same cycle as a matching commit -> that commit still hits entry 0; an identical commit the next cycle does not.
